// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte-stream requesters.
// The owner keeps the line for a whole packet; a stalled owner is released after TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    localparam int IW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [IW-1:0]        grant_id,
    output logic                 timeout_err,
    output logic [2:0]           dbg_state
);
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic [IW-1:0]   r_ptr, w_ptr_nx;
    logic [IW-1:0]   r_gid, w_gid_nx;
    logic            r_gv, w_gv_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic            r_last, w_last_nx;
    logic [7:0]      r_tx_data, w_data_nx;
    logic            r_tx_start, w_start_nx;
    logic            r_timeout, w_to_nx;

    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic            w_xfer;
    logic            w_to_hit;
    logic [IW-1:0]   w_next_ptr;

    // A byte moves on a cycle where req_valid[g] and req_ready[g] are both high; ready only
    // rises for the owner while waiting for a byte and the transmitter is idle.
    assign w_xfer     = (r_state == S_SEND) && req_valid[r_gid] && !tx_busy;
    assign w_to_hit   = (TIMEOUT != 0) && (({1'b0, r_cnt} + 1'b1) == CW1'(TIMEOUT));
    assign w_next_ptr = (r_gid == IW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_xfer) req_ready[r_gid] = 1'b1;
    end

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_gid_nx   = r_gid;
        w_gv_nx    = r_gv;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_data_nx  = r_tx_data;
        w_start_nx = 1'b0;
        w_to_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gv_nx    = 1'b1;
                    w_gid_nx   = w_pick;
                    w_cnt_nx   = '0;
                    w_state_nx = S_SEND;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_data_nx  = req_data[{r_gid, 3'b000} +: 8];
                    w_last_nx  = req_last[r_gid];
                    w_cnt_nx   = '0;
                    w_start_nx = 1'b1;
                    w_state_nx = S_START;
                end else if (!req_valid[r_gid]) begin
                    if (w_to_hit) begin
                        w_to_nx    = 1'b1;
                        w_gv_nx    = 1'b0;
                        w_ptr_nx   = w_next_ptr;
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            S_START: w_state_nx = S_WAIT_HI;
            S_WAIT_HI: begin
                if (tx_busy) w_state_nx = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    w_cnt_nx = '0;
                    if (r_last) begin
                        w_gv_nx    = 1'b0;
                        w_ptr_nx   = w_next_ptr;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_SEND;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gid      <= '0;
            r_gv       <= 1'b0;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_gid      <= w_gid_nx;
            r_gv       <= w_gv_nx;
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last_nx;
            r_tx_data  <= w_data_nx;
            r_tx_start <= w_start_nx;
            r_timeout  <= w_to_nx;
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign grant_valid = r_gv;
    assign grant_id    = r_gid;
    assign timeout_err = r_timeout;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a busy-pulse transmitter model and a
// transaction-level reference of grants, transfers, start pulses and timeouts.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_start, tx_busy, grant_valid, timeout_err;
    logic [7:0]     tx_data;
    logic [IW-1:0]  grant_id;
    logic [2:0]     dbg_state;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus sources: {last, data} per requester
    logic [8:0] src_q [N][$];
    logic [N-1:0] hold;
    bit   rand_hold;
    int   bcnt, blen_min, blen_max;

    // reference model of the arbiter at transaction level
    bit   m_gv, m_inflight, m_start, m_busy_seen, m_last, m_to;
    int   m_gid, m_ptr, m_cnt;
    logic [7:0] exp_q [$];

    // observations
    int   obs_tx [$];
    int   obs_g [$];
    int   obs_to;
    bit   prev_gv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int obs[$], input int n, input logic [63:0] exp);
        chk({tag, "_len"}, obs.size(), n);
        for (int k = 0; k < n; k++)
            if (k < obs.size()) chk(tag, obs[k], {24'd0, exp[8*k +: 8]});
    endtask

    task automatic model_reset();
        m_gv = 0; m_inflight = 0; m_start = 0; m_busy_seen = 0; m_last = 0; m_to = 0;
        m_gid = 0; m_ptr = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_q[i].size() > 0) && !hold[i];
            if (req_valid[i]) begin
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        src_q[i].push_back({l, d});
        drive_req();
    endtask

    // One clock: check outputs against the model at the negedge, advance the model, then drive.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit nxt_start, nxt_to, found;
        int g;
        @(negedge clk);
        g = m_gid;
        chk("grant_valid", grant_valid, m_gv);
        if (m_gv) chk("grant_id", grant_id, m_gid);
        chk("tx_start", tx_start, m_start);
        if (m_start && exp_q.size() > 0) chk("tx_data", tx_data, exp_q.pop_front());
        chk("timeout_err", timeout_err, m_to);
        chk("start_while_busy", tx_start & tx_busy, 0);
        exp_ready = '0;
        if (m_gv && !m_inflight) exp_ready[g] = req_valid[g] & ~tx_busy;
        chk("req_ready", req_ready, exp_ready);

        if (tx_start) begin
            obs_tx.push_back(tx_data);
            bcnt = $urandom_range(blen_min, blen_max);
        end
        if (grant_valid && !prev_gv) obs_g.push_back(grant_id);
        prev_gv = grant_valid;
        if (timeout_err) obs_to++;

        if (rst) begin
            model_reset();
        end else begin
            nxt_start = 0;
            nxt_to    = 0;
            if (!m_gv) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1; m_gv = 1; m_gid = idx; m_cnt = 0;
                    end
                end
            end else if (!m_inflight) begin
                if (req_valid[g] && !tx_busy) begin
                    exp_q.push_back(req_data[8*g +: 8]);
                    m_last = req_last[g];
                    void'(src_q[g].pop_front());
                    m_inflight = 1; m_busy_seen = 0; nxt_start = 1; m_cnt = 0;
                end else if (!req_valid[g]) begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        nxt_to = 1; m_gv = 0; m_ptr = (g + 1) % N; m_cnt = 0;
                    end
                end
            end else if (!m_start) begin
                if (!m_busy_seen) begin
                    if (tx_busy) m_busy_seen = 1;
                end else if (!tx_busy) begin
                    m_inflight = 0; m_cnt = 0;
                    if (m_last) begin
                        m_gv = 0; m_ptr = (g + 1) % N;
                    end
                end
            end
            m_start = nxt_start;
            m_to    = nxt_to;
        end

        @(posedge clk);
        #1;
        if (bcnt > 0) begin
            tx_busy = 1'b1;
            bcnt--;
        end else begin
            tx_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) hold[i] = rand_hold ? ($urandom_range(0, 9) == 0) : 1'b0;
        drive_req();
    endtask

    function automatic bit busy_any();
        bit b;
        b = m_gv || m_inflight;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1;
        return b;
    endfunction

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        while (busy_any() && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_drained"}, {31'd0, busy_any()}, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gv"}, grant_valid, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_to"}, timeout_err, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic clear_obs();
        obs_tx.delete();
        obs_g.delete();
        obs_to = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    initial begin
        int c, nbytes;
        rst = 1'b1; tx_busy = 1'b0; bcnt = 0; hold = '0; rand_hold = 0;
        blen_min = 10; blen_max = 10; prev_gv = 0; obs_to = 0;
        req_valid = '0; req_last = '0; req_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check_idle_outputs("reset");

        // single byte on requester 0
        clear_obs();
        push(0, 8'hA5, 1'b1);
        drain("t1", 200);
        check_seq("t1_tx", obs_tx, 1, 64'hA5);
        check_seq("t1_grant", obs_g, 1, 64'h00);

        // multi-byte packet on requester 2 while requester 1 waits
        clear_obs();
        blen_min = 1; blen_max = 12;
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        step(); step();
        push(1, 8'h44, 1'b1);
        drain("t2", 400);
        check_seq("t2_tx", obs_tx, 4, 64'h44_33_22_11);
        check_seq("t2_grant", obs_g, 2, 64'h01_02);

        // reset in the middle of requester 1's second byte
        clear_obs();
        push(1, 8'h01, 1'b0); push(1, 8'h02, 1'b0); push(1, 8'h03, 1'b1);
        c = 0;
        while (!(src_q[1].size() == 1 && m_inflight && m_busy_seen && !m_start) && c < 300) begin
            step();
            c++;
        end
        chk("t5_reached_wait_lo", {31'd0, m_busy_seen}, 1);
        push(0, 8'h77, 1'b1);
        do_reset();
        drain("t5", 400);
        check_seq("t5_tx", obs_tx, 4, 64'h03_77_02_01);
        check_seq("t5_grant", obs_g, 3, 64'h01_00_01);

        // round robin with every requester holding two single-byte packets
        do_reset();
        clear_obs();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(16 * i + r), 1'b1);
        drain("t3", 800);
        check_seq("t3_grant", obs_g, 8, 64'h03_02_01_00_03_02_01_00);
        check_seq("t3_tx", obs_tx, 8, 64'h31_21_11_01_30_20_10_00);

        // forced release of a stalled packet
        clear_obs();
        push(3, 8'h55, 1'b0);
        c = 0;
        while (!(m_gv && m_gid == 3) && c < 50) begin
            step();
            c++;
        end
        push(0, 8'h99, 1'b1);
        drain("t4", 400);
        chk("t4_timeouts", obs_to, 1);
        check_seq("t4_grant", obs_g, 2, 64'h00_03);
        check_seq("t4_tx", obs_tx, 2, 64'h99_55);

        // randomized traffic with stalls and variable transmitter busy time
        clear_obs();
        rand_hold = 1;
        nbytes = 0;
        for (int p = 0; p < 150; p++) begin
            int who, len;
            who = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                push(who, 8'($urandom), (b == len - 1));
                nbytes++;
            end
        end
        drain("rand", 40000);
        chk("rand_tx_count", obs_tx.size(), nbytes);
        chk("rand_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
